multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS datapath, directly upstream of the ALU-control decoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback, driving datapath mux selects and write enables.
- Supplies the 2-bit aluOp consumed by the ALU-control decoder: 00 add, 01 subtract/compare, 10 use funct.
- Stalls on a memory-ready handshake and traps illegal opcodes.

---
 rtl/mips_pkg.sv | 78 +++++++
 rtl/multicycle_control_decode.sv | 82 ++++++++
 rtl/multicycle_control.sv | 80 ++++++++
 tb/tb_multicycle_control.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, ALU op,
// datapath select codes, FSM states and the packed control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPEEX  = 4'd6,
        S_RTYPEWB  = 4'd7,
        S_BRANCHEX = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JEX      = 4'd11
    } state_t;

    typedef struct packed {
        logic       memRead;
        logic       memWrite;
        logic       iord;
        logic       irWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
        logic       pcEn;
        logic       illegalOp;
        logic       instrDone;
    } ctrl_t;

    // Dispatch target out of DECODE; unknown opcodes return to FETCH.
    function automatic state_t decode_target(input logic [5:0] op, input logic bne_en);
        state_t t;
        t = S_FETCH;
        case (op)
            OP_LW, OP_SW: t = S_MEMADR;
            OP_RTYPE:     t = S_RTYPEEX;
            OP_BEQ:       t = S_BRANCHEX;
            OP_BNE:       t = bne_en ? S_BRANCHEX : S_FETCH;
            OP_ADDI:      t = S_ADDIEX;
            OP_J:         t = S_JEX;
            default:      t = S_FETCH;
        endcase
        return t;
    endfunction

    function automatic logic op_legal(input logic [5:0] op, input logic bne_en);
        return decode_target(op, bne_en) != S_FETCH;
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Combinational map from FSM state (plus opcode/zero/memReady) to the
// datapath control word.
module mc_ctrl_decode
    import mips_pkg::*;
#(
    parameter bit BNE_EN = 1'b1
) (
    input  state_t     i_state,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.memRead = 1'b1;
                o_ctrl.aluSrcB = SRCB_FOUR;
                o_ctrl.aluOp   = ALUOP_ADD;
                o_ctrl.pcSrc   = PCSRC_ALU;
                o_ctrl.irWrite = i_mem_ready;
                o_ctrl.pcEn    = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.aluSrcB   = SRCB_IMMSH2;
                o_ctrl.aluOp     = ALUOP_ADD;
                o_ctrl.illegalOp = ~op_legal(i_opcode, BNE_EN);
            end
            S_MEMADR, S_ADDIEX: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = SRCB_IMM;
                o_ctrl.aluOp   = ALUOP_ADD;
            end
            S_MEMRD: begin
                o_ctrl.memRead = 1'b1;
                o_ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                o_ctrl.memToReg  = 1'b1;
                o_ctrl.regWrite  = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            S_MEMWR: begin
                o_ctrl.memWrite  = 1'b1;
                o_ctrl.iord      = 1'b1;
                o_ctrl.instrDone = i_mem_ready;
            end
            S_RTYPEEX: begin
                o_ctrl.aluSrcA = 1'b1;
                o_ctrl.aluSrcB = SRCB_REG;
                o_ctrl.aluOp   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                o_ctrl.regDst    = 1'b1;
                o_ctrl.regWrite  = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            S_BRANCHEX: begin
                o_ctrl.aluSrcA   = 1'b1;
                o_ctrl.aluSrcB   = SRCB_REG;
                o_ctrl.aluOp     = ALUOP_SUB;
                o_ctrl.pcSrc     = PCSRC_ALUOUT;
                o_ctrl.instrDone = 1'b1;
                // bne only reaches here when enabled, so opcode alone picks the sense
                o_ctrl.pcEn      = (i_opcode == OP_BNE) ? ~i_zero : i_zero;
            end
            S_ADDIWB: begin
                o_ctrl.regWrite  = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            S_JEX: begin
                o_ctrl.pcSrc     = PCSRC_JUMP;
                o_ctrl.pcEn      = 1'b1;
                o_ctrl.instrDone = 1'b1;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: state register, next-state logic and
// reset gating of the control word produced by mc_ctrl_decode.
module multicycle_control
    import mips_pkg::*;
#(
    parameter bit BNE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       memReady,
    output logic       memRead,
    output logic       memWrite,
    output logic       iord,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSrc,
    output logic       pcEn,
    output logic       illegalOp,
    output logic       instrDone
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_dec;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:   w_next = memReady ? S_DECODE : S_FETCH;
            S_DECODE:  w_next = decode_target(opcode, BNE_EN);
            // IR holds still past FETCH, so the opcode is safe to look at again
            S_MEMADR:  w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   w_next = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:   w_next = memReady ? S_FETCH : S_MEMWR;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            default:   w_next = S_FETCH;
        endcase
    end

    mc_ctrl_decode #(.BNE_EN(BNE_EN)) u_decode (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_zero      (zero),
        .i_mem_ready (memReady),
        .o_ctrl      (w_dec)
    );

    // Reset kills every request and write enable in the same cycle.
    assign w_ctrl = reset ? ctrl_t'('0) : w_dec;

    assign memRead   = w_ctrl.memRead;
    assign memWrite  = w_ctrl.memWrite;
    assign iord      = w_ctrl.iord;
    assign irWrite   = w_ctrl.irWrite;
    assign regDst    = w_ctrl.regDst;
    assign memToReg  = w_ctrl.memToReg;
    assign regWrite  = w_ctrl.regWrite;
    assign aluSrcA   = w_ctrl.aluSrcA;
    assign aluSrcB   = w_ctrl.aluSrcB;
    assign aluOp     = w_ctrl.aluOp;
    assign pcSrc     = w_ctrl.pcSrc;
    assign pcEn      = w_ctrl.pcEn;
    assign illegalOp = w_ctrl.illegalOp;
    assign instrDone = w_ctrl.instrDone;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle control words checked
// against hand-written constants, on a bne-enabled and a bne-disabled copy.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       memReady;

    logic       memRead, memWrite, iord, irWrite, regDst, memToReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSrc;
    logic       pcEn, illegalOp, instrDone;

    logic       memRead0, memWrite0, iord0, irWrite0, regDst0, memToReg0, regWrite0, aluSrcA0;
    logic [1:0] aluSrcB0, aluOp0, pcSrc0;
    logic       pcEn0, illegalOp0, instrDone0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multicycle_control #(.BNE_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
        .memRead(memRead), .memWrite(memWrite), .iord(iord), .irWrite(irWrite),
        .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite), .aluSrcA(aluSrcA),
        .aluSrcB(aluSrcB), .aluOp(aluOp), .pcSrc(pcSrc), .pcEn(pcEn),
        .illegalOp(illegalOp), .instrDone(instrDone)
    );

    multicycle_control #(.BNE_EN(1'b0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .memReady(memReady),
        .memRead(memRead0), .memWrite(memWrite0), .iord(iord0), .irWrite(irWrite0),
        .regDst(regDst0), .memToReg(memToReg0), .regWrite(regWrite0), .aluSrcA(aluSrcA0),
        .aluSrcB(aluSrcB0), .aluOp(aluOp0), .pcSrc(pcSrc0), .pcEn(pcEn0),
        .illegalOp(illegalOp0), .instrDone(instrDone0)
    );

    // {memRead,memWrite,iord,irWrite, regDst,memToReg,regWrite,aluSrcA,
    //  aluSrcB, aluOp, pcSrc, pcEn,illegalOp,instrDone}
    localparam logic [16:0] W_ZERO    = 17'b0000_0000_00_00_00_000;
    localparam logic [16:0] W_FETCH   = 17'b1001_0000_01_00_00_100;
    localparam logic [16:0] W_FETCHST = 17'b1000_0000_01_00_00_000;
    localparam logic [16:0] W_DECODE  = 17'b0000_0000_11_00_00_000;
    localparam logic [16:0] W_ILLEGAL = 17'b0000_0000_11_00_00_010;
    localparam logic [16:0] W_MEMADR  = 17'b0000_0001_10_00_00_000;
    localparam logic [16:0] W_MEMRD   = 17'b1010_0000_00_00_00_000;
    localparam logic [16:0] W_MEMWB   = 17'b0000_0110_00_00_00_001;
    localparam logic [16:0] W_MEMWRST = 17'b0110_0000_00_00_00_000;
    localparam logic [16:0] W_MEMWR   = 17'b0110_0000_00_00_00_001;
    localparam logic [16:0] W_RTEX    = 17'b0000_0001_00_10_00_000;
    localparam logic [16:0] W_RTWB    = 17'b0000_1010_00_00_00_001;
    localparam logic [16:0] W_BRTAKE  = 17'b0000_0001_00_01_01_101;
    localparam logic [16:0] W_BRNOT   = 17'b0000_0001_00_01_01_001;
    localparam logic [16:0] W_ADDIEX  = 17'b0000_0001_10_00_00_000;
    localparam logic [16:0] W_ADDIWB  = 17'b0000_0010_00_00_00_001;
    localparam logic [16:0] W_JEX     = 17'b0000_0000_00_00_10_101;

    logic [16:0] w_obs, w_obs0;
    assign w_obs  = {memRead, memWrite, iord, irWrite, regDst, memToReg, regWrite, aluSrcA,
                     aluSrcB, aluOp, pcSrc, pcEn, illegalOp, instrDone};
    assign w_obs0 = {memRead0, memWrite0, iord0, irWrite0, regDst0, memToReg0, regWrite0, aluSrcA0,
                     aluSrcB0, aluOp0, pcSrc0, pcEn0, illegalOp0, instrDone0};

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the negedge, check the BNE_EN=1 copy, advance.
    task automatic cyc(input logic [5:0] op, input logic z, input logic rdy,
                       input string tag, input logic [16:0] exp);
        opcode = op; zero = z; memReady = rdy;
        #1;
        chk(tag, w_obs, exp);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; opcode = 6'd0; zero = 1'b0; memReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("reset_outputs", w_obs, W_ZERO);
        chk("reset_outputs_nobne", w_obs0, W_ZERO);
        @(negedge clk);
        reset = 1'b0;

        // lw, no stalls: 5 cycles
        cyc(6'd35, 1'b0, 1'b1, "lw_fetch",  W_FETCH);
        cyc(6'd35, 1'b0, 1'b1, "lw_decode", W_DECODE);
        cyc(6'd35, 1'b0, 1'b1, "lw_memadr", W_MEMADR);
        cyc(6'd35, 1'b0, 1'b1, "lw_memrd",  W_MEMRD);
        cyc(6'd35, 1'b0, 1'b1, "lw_memwb",  W_MEMWB);

        // sw with 3 wait cycles in MEMWR: 7 cycles
        cyc(6'd43, 1'b0, 1'b1, "sw_fetch",   W_FETCH);
        cyc(6'd43, 1'b0, 1'b1, "sw_decode",  W_DECODE);
        cyc(6'd43, 1'b0, 1'b1, "sw_memadr",  W_MEMADR);
        cyc(6'd43, 1'b0, 1'b0, "sw_wait1",   W_MEMWRST);
        cyc(6'd43, 1'b0, 1'b0, "sw_wait2",   W_MEMWRST);
        cyc(6'd43, 1'b0, 1'b0, "sw_wait3",   W_MEMWRST);
        cyc(6'd43, 1'b0, 1'b1, "sw_done",    W_MEMWR);

        // R-type
        cyc(6'd0, 1'b0, 1'b1, "rt_fetch",  W_FETCH);
        cyc(6'd0, 1'b0, 1'b1, "rt_decode", W_DECODE);
        cyc(6'd0, 1'b0, 1'b1, "rt_ex",     W_RTEX);
        cyc(6'd0, 1'b0, 1'b1, "rt_wb",     W_RTWB);

        // beq taken / not taken
        cyc(6'd4, 1'b1, 1'b1, "beq1_fetch",  W_FETCH);
        cyc(6'd4, 1'b1, 1'b1, "beq1_decode", W_DECODE);
        cyc(6'd4, 1'b1, 1'b1, "beq_taken",   W_BRTAKE);
        cyc(6'd4, 1'b0, 1'b1, "beq0_fetch",  W_FETCH);
        cyc(6'd4, 1'b0, 1'b1, "beq0_decode", W_DECODE);
        cyc(6'd4, 1'b0, 1'b1, "beq_nottaken", W_BRNOT);

        // bne taken / not taken
        cyc(6'd5, 1'b0, 1'b1, "bne0_fetch",  W_FETCH);
        cyc(6'd5, 1'b0, 1'b1, "bne0_decode", W_DECODE);
        cyc(6'd5, 1'b0, 1'b1, "bne_taken",   W_BRTAKE);
        cyc(6'd5, 1'b1, 1'b1, "bne1_fetch",  W_FETCH);
        cyc(6'd5, 1'b1, 1'b1, "bne1_decode", W_DECODE);
        cyc(6'd5, 1'b1, 1'b1, "bne_nottaken", W_BRNOT);

        // addi, with one stall cycle in FETCH
        cyc(6'd8, 1'b0, 1'b0, "addi_fetchst", W_FETCHST);
        cyc(6'd8, 1'b0, 1'b1, "addi_fetch",   W_FETCH);
        cyc(6'd8, 1'b0, 1'b1, "addi_decode",  W_DECODE);
        cyc(6'd8, 1'b0, 1'b1, "addi_ex",      W_ADDIEX);
        cyc(6'd8, 1'b0, 1'b1, "addi_wb",      W_ADDIWB);

        // j
        cyc(6'd2, 1'b0, 1'b1, "j_fetch",  W_FETCH);
        cyc(6'd2, 1'b0, 1'b1, "j_decode", W_DECODE);
        cyc(6'd2, 1'b0, 1'b1, "j_ex",     W_JEX);

        // lw with one stall in MEMRD
        cyc(6'd35, 1'b0, 1'b1, "lwst_fetch",  W_FETCH);
        cyc(6'd35, 1'b0, 1'b1, "lwst_decode", W_DECODE);
        cyc(6'd35, 1'b0, 1'b1, "lwst_memadr", W_MEMADR);
        cyc(6'd35, 1'b0, 1'b0, "lwst_wait",   W_MEMRD);
        cyc(6'd35, 1'b0, 1'b1, "lwst_memrd",  W_MEMRD);
        cyc(6'd35, 1'b0, 1'b1, "lwst_memwb",  W_MEMWB);

        // illegal opcode 63
        cyc(6'd63, 1'b0, 1'b1, "ill_fetch",  W_FETCH);
        cyc(6'd63, 1'b0, 1'b1, "ill_decode", W_ILLEGAL);
        cyc(6'd0,  1'b0, 1'b1, "ill_refetch", W_FETCH);

        // reset for 2 cycles in RTYPEEX (previous cycle was FETCH of an R-type)
        cyc(6'd0, 1'b0, 1'b1, "rst_decode", W_DECODE);
        reset = 1'b1;
        cyc(6'd0, 1'b0, 1'b1, "rst_mid1", W_ZERO);
        cyc(6'd0, 1'b0, 1'b1, "rst_mid2", W_ZERO);
        reset = 1'b0;
        opcode = 6'd5; zero = 1'b0; memReady = 1'b1;
        #1;
        chk("rst_release_fetch",       w_obs,  W_FETCH);
        chk("rst_release_fetch_nobne", w_obs0, W_FETCH);
        @(negedge clk);

        // BNE_EN=0 copy: opcode 5 is illegal
        #1;
        chk("nobne_decode", w_obs0, W_ILLEGAL);
        chk("bne_decode",   w_obs,  W_DECODE);
        @(negedge clk);
        #1;
        chk("nobne_refetch", w_obs0, W_FETCH);
        chk("bne_branch",    w_obs,  W_BRTAKE);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
